apb_master_arb: RTL
===================

Name: apb_master_arb

Overview:
- Two-requester APB master that sequences APB transfers to the GPIO and UART APB slaves on a single shared APB bus.
- Each requester uses a simple valid/ready command port. The block round-robin arbitrates between them, decodes the address into PSEL_GPIO or PSEL_UART, and runs the SETUP/ACCESS protocol with a wait-state timeout.
- It returns read data and an error flag to the granted requester.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (PSTRB is DATA_WIDTH/8 bits)
TIMEOUT, 15, maximum ACCESS cycles with PREADY low before forced termination

Ports:
PCLK  in  1  clock; everything is sampled on the rising edge
PRESET  in  1  asynchronous, active-high reset
reqN_valid (N=0,1)  in  1  command request
reqN_write  in  1  1=write, 0=read
reqN_addr  in  ADDR_WIDTH  target address
reqN_wdata  in  DATA_WIDTH  write data
reqN_strb  in  DATA_WIDTH/8  write byte strobes
reqN_ready  out  1  one-cycle pulse: command accepted
reqN_done  out  1  one-cycle pulse: transfer complete
reqN_rdata  out  DATA_WIDTH  read data, valid while reqN_done=1
reqN_err  out  1  error, valid while reqN_done=1
PADDR, PWRITE, PWDATA, PSTRB, PENABLE  out  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8/1  shared APB master outputs
PSEL_GPIO, PSEL_UART  out  1  per-slave selects
PRDATA_GPIO, PRDATA_UART  in  DATA_WIDTH  slave read data
PREADY_GPIO, PREADY_UART, PSLVERR_GPIO, PSLVERR_UART  in  1  slave responses

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0. FSM goes to IDLE. Timeout counter goes to 0. Round-robin pointer last_grant=1, so req0 wins first.
  - Reset during SETUP or ACCESS drops PSEL/PENABLE immediately. No done is issued for the aborted transfer.
- Address decode on PADDR[15:12]:
  - 4'h0 selects GPIO.
  - 4'h1 selects UART.
  - Any other value is a decode error.
- FSM states: IDLE, SETUP, ACCESS, DERR.
- IDLE:
  - If any reqN_valid=1, grant per round-robin: the sole requester, or the one that is not last_grant when both request.
  - Pulse reqN_ready, latch addr/write/wdata/strb, update last_grant.
  - Next state is SETUP, or DERR on a decode error.
- SETUP (one cycle): selected PSEL=1, PENABLE=0; PADDR, PWRITE, PWDATA, PSTRB driven from the latched command. Next state is ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; all APB outputs held stable.
  - Each cycle with the selected PREADY=0 increments the counter.
  - PREADY=1: capture PRDATA (reads only; writes return 0) and capture PSLVERR → err; go to IDLE.
  - Counter reaches TIMEOUT with PREADY still 0: err=1, rdata=0; go to IDLE.
  - PSEL and PENABLE are deasserted on entry to IDLE.
- DERR (one cycle): no PSEL asserted. Sets err=1, rdata=0, then goes to IDLE.
- reqN_done is registered and pulses in the cycle after completion, together with rdata/err. The FSM may grant a new command in that same IDLE cycle.
- Minimum transfer cost: 3 cycles (IDLE, SETUP, ACCESS).
- Reads drive PSTRB=0 and PWDATA=0.
- Only the granted requester's done/rdata/err change; the other requester's outputs stay 0.
- Command-port rules:
  - A requester that drops valid before its ready pulse loses the request; nothing is issued.
  - Valid still high after ready is treated as a new command.
- At most one APB transfer is outstanding. No PSEL is asserted outside SETUP/ACCESS.

Decomposition:
- Package apb_ctrl_pkg holds:
  - the FSM state enum;
  - the region codes (REGION_GPIO=4'h0, REGION_UART=4'h1);
  - the decode bit positions.
- Sub-module apb_rr_arb: 2-way round-robin arbiter with inputs req[1:0] and advance, outputs grant[1:0], and the last_grant register inside it.

Test Plan:
1. req0 write addr 0x0000_0004, wdata 0x1, strb 4'b0001, PREADY_GPIO=1 → PSEL_GPIO high 2 cycles, PENABLE only in the 2nd, PSTRB=0001; req0_done pulses once, req0_err=0.
2. req1 read addr 0x0000_1000, PREADY_UART low for 3 ACCESS cycles, PRDATA_UART=0x0000_00A5 → ACCESS lasts 4 cycles, PSTRB=0, req1_rdata=0x0000_00A5, err=0.
3. Both valid continuously from reset for 4 transfers → grant order 0,1,0,1; ready pulses never coincide.
4. req0 addr 0x0000_3000 → no PSEL asserted; req0_done with err=1 and rdata=0, 2 cycles after ready.
5. PREADY_GPIO held 0, TIMEOUT=15 → PENABLE drops after 15 ACCESS cycles; done with err=1 and rdata=0; the next request proceeds normally.
6. PSLVERR_UART=1 with PREADY → err=1. Then assert PRESET mid-ACCESS → PSEL/PENABLE go to 0 immediately, no done pulse; after reset, req0 wins first.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// rtl/apb_ctrl_pkg.sv - FSM states and address-decode constants for apb_master_arb
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DERR
  } state_t;

  localparam logic [3:0] REGION_GPIO = 4'h0;
  localparam logic [3:0] REGION_UART = 4'h1;

  localparam int DEC_LSB = 12;
  localparam int DEC_MSB = 15;

endpackage

// File: rtl/apb_rr_arb.sv
// rtl/apb_rr_arb.sv - two-way round-robin arbiter, last_grant resets to 1 so req0 wins first
module apb_rr_arb
  import apb_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic r_last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      r_last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// rtl/apb_master_arb.sv - two-requester APB master with GPIO/UART decode and wait-state timeout
module apb_master_arb
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                    PCLK,
  input  logic                    PRESET,

  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_strb,
  output logic                    req0_ready,
  output logic                    req0_done,
  output logic [DATA_WIDTH-1:0]   req0_rdata,
  output logic                    req0_err,

  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_strb,
  output logic                    req1_ready,
  output logic                    req1_done,
  output logic [DATA_WIDTH-1:0]   req1_rdata,
  output logic                    req1_err,

  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PENABLE,
  output logic                    PSEL_GPIO,
  output logic                    PSEL_UART,
  input  logic [DATA_WIDTH-1:0]   PRDATA_GPIO,
  input  logic [DATA_WIDTH-1:0]   PRDATA_UART,
  input  logic                    PREADY_GPIO,
  input  logic                    PREADY_UART,
  input  logic                    PSLVERR_GPIO,
  input  logic                    PSLVERR_UART
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                r_state, w_next;
  logic [1:0]            w_grant;
  logic                  w_advance;
  logic                  r_owner;
  logic                  r_uart;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SW-1:0]         r_strb;
  logic [CW-1:0]         r_cnt;

  logic                  r_done0, r_done1, r_err0, r_err1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

  logic [ADDR_WIDTH-1:0] w_g_addr;
  logic                  w_g_write;
  logic [DATA_WIDTH-1:0] w_g_wdata;
  logic [SW-1:0]         w_g_strb;
  logic [3:0]            w_g_region;
  logic                  w_dec_err;
  logic                  w_pready, w_pslverr;
  logic [DATA_WIDTH-1:0] w_prdata;
  logic                  w_complete, w_cpl_err;
  logic [DATA_WIDTH-1:0] w_cpl_rdata;
  logic                  w_active;

  apb_rr_arb u_arb (
    .clk     (PCLK),
    .rst     (PRESET),
    .req     ({req1_valid, req0_valid}),
    .advance (w_advance),
    .grant   (w_grant)
  );

  assign w_g_addr   = w_grant[1] ? req1_addr  : req0_addr;
  assign w_g_write  = w_grant[1] ? req1_write : req0_write;
  assign w_g_wdata  = w_grant[1] ? req1_wdata : req0_wdata;
  assign w_g_strb   = w_grant[1] ? req1_strb  : req0_strb;
  assign w_g_region = w_g_addr[DEC_MSB:DEC_LSB];
  assign w_dec_err  = (w_g_region != REGION_GPIO) && (w_g_region != REGION_UART);

  assign w_pready  = r_uart ? PREADY_UART  : PREADY_GPIO;
  assign w_pslverr = r_uart ? PSLVERR_UART : PSLVERR_GPIO;
  assign w_prdata  = r_uart ? PRDATA_UART  : PRDATA_GPIO;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_advance   = 1'b0;
    w_complete  = 1'b0;
    w_cpl_err   = 1'b0;
    w_cpl_rdata = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant != 2'b00) begin
          w_advance = 1'b1;
          w_next    = w_dec_err ? ST_DERR : ST_SETUP;
        end
      end
      ST_SETUP: w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (w_pready) begin
          w_complete  = 1'b1;
          w_cpl_err   = w_pslverr;
          w_cpl_rdata = r_write ? '0 : w_prdata;
          w_next      = ST_IDLE;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_complete = 1'b1;
          w_cpl_err  = 1'b1;
          w_next     = ST_IDLE;
        end
      end
      ST_DERR: begin
        w_complete = 1'b1;
        w_cpl_err  = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read commands latch zero write data/strobes so the bus shows 0 for reads
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_owner  <= 1'b0;
      r_uart   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_cnt    <= '0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_advance) begin
        r_owner <= w_grant[1];
        r_uart  <= (w_g_region == REGION_UART);
        r_write <= w_g_write;
        r_addr  <= w_g_addr;
        r_wdata <= w_g_write ? w_g_wdata : '0;
        r_strb  <= w_g_write ? w_g_strb  : '0;
      end
      if ((r_state == ST_ACCESS) && (w_next == ST_ACCESS)) r_cnt <= r_cnt + 1'b1;
      else                                                r_cnt <= '0;
      r_done0  <= w_complete & ~r_owner;
      r_done1  <= w_complete &  r_owner;
      r_err0   <= w_complete & ~r_owner & w_cpl_err;
      r_err1   <= w_complete &  r_owner & w_cpl_err;
      r_rdata0 <= (w_complete & ~r_owner) ? w_cpl_rdata : '0;
      r_rdata1 <= (w_complete &  r_owner) ? w_cpl_rdata : '0;
    end
  end

  assign w_active   = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign PSEL_GPIO  = w_active & ~r_uart;
  assign PSEL_UART  = w_active &  r_uart;
  assign PENABLE    = (r_state == ST_ACCESS);
  assign PADDR      = r_addr;
  assign PWRITE     = r_write;
  assign PWDATA     = r_wdata;
  assign PSTRB      = r_strb;

  assign req0_ready = w_advance & w_grant[0] & ~PRESET;
  assign req1_ready = w_advance & w_grant[1] & ~PRESET;
  assign req0_done  = r_done0;
  assign req1_done  = r_done1;
  assign req0_err   = r_err0;
  assign req1_err   = r_err1;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;

endmodule
